date_counter: RTL and testbench

- Calendar day/month/year register stage for the millennium clock.
- Advances the date on each day tick from the time-of-day counter and accepts user date loads with validation.
- Drives month/year to the existing leap_year_check block and consumes its combinational max_day to decide month rollover and clamp loaded days.
- Year is stored as an offset: absolute year = 2025 + year.

---
 rtl/date_counter_if.sv | 26 ++
 rtl/date_counter.sv | 142 ++++++++++++++
 tb/tb_date_counter.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/date_counter_if.sv
// Date counter port bundle: tick/load controls, leap_year_check max_day feedback and the date outputs.
// master drives controls and max_day; slave is the date_counter itself.
interface date_counter_if;
  logic       day_tick;
  logic       set_en;
  logic [4:0] set_day;
  logic [3:0] set_month;
  logic [9:0] set_year;
  logic [4:0] max_day;
  logic [4:0] day;
  logic [3:0] month;
  logic [9:0] year;
  logic       busy;
  logic       set_err;
  logic       year_wrap;

  modport master (
    output day_tick, set_en, set_day, set_month, set_year, max_day,
    input  day, month, year, busy, set_err, year_wrap
  );

  modport slave (
    input  day_tick, set_en, set_day, set_month, set_year, max_day,
    output day, month, year, busy, set_err, year_wrap
  );
endinterface

// File: rtl/date_counter.sv
// Calendar day/month/year register stage with validated user loads.
// Year is an offset from 2025; max_day is fed back from leap_year_check for the current month/year.
module date_counter #(
  parameter int unsigned YEAR_MAX = 974
) (
  input  logic          clk,
  input  logic          rst,
  date_counter_if.slave bus
);

  // state  | meaning
  // IDLE   | advance on ticks, accept loads, drain a pending tick
  // VERIFY | one cycle after a load; clamp day to the new month's max_day
  typedef enum logic {IDLE, VERIFY} state_t;

  localparam logic [9:0] YEAR_LAST = 10'(YEAR_MAX);

  state_t     state_q, state_d;
  logic [4:0] day_q, day_d;
  logic [3:0] month_q, month_d;
  logic [9:0] year_q, year_d;
  logic       busy_q, busy_d;
  logic       set_err_q, set_err_d;
  logic       year_wrap_q, year_wrap_d;
  logic       pend_q, pend_d;

  logic [4:0] inc_day;
  logic [3:0] inc_month;
  logic [9:0] inc_year;
  logic       inc_wrap;
  logic       set_ok;

  // Next date after one day, from the current registers and max_day.
  always_comb begin
    inc_day   = day_q;
    inc_month = month_q;
    inc_year  = year_q;
    inc_wrap  = 1'b0;
    if (day_q < bus.max_day) begin
      inc_day = day_q + 5'd1;
    end else begin
      inc_day = 5'd1;
      if (month_q < 4'd12) begin
        inc_month = month_q + 4'd1;
      end else begin
        inc_month = 4'd1;
        if (year_q < YEAR_LAST) begin
          inc_year = year_q + 10'd1;
        end else begin
          inc_year = 10'd0;
          inc_wrap = 1'b1;
        end
      end
    end
  end

  assign set_ok = (bus.set_month != 4'd0) && (bus.set_month <= 4'd12) &&
                  (bus.set_day != 5'd0) && (bus.set_year <= YEAR_LAST);

  always_comb begin
    state_d     = state_q;
    day_d       = day_q;
    month_d     = month_q;
    year_d      = year_q;
    busy_d      = 1'b0;
    set_err_d   = 1'b0;
    year_wrap_d = 1'b0;
    pend_d      = pend_q;

    case (state_q)
      IDLE: begin
        if (pend_q) begin
          // A tick arriving now is banked so only one day advances per cycle.
          day_d       = inc_day;
          month_d     = inc_month;
          year_d      = inc_year;
          year_wrap_d = inc_wrap;
          pend_d      = bus.day_tick;
        end else if (bus.set_en) begin
          if (set_ok) begin
            day_d   = bus.set_day;
            month_d = bus.set_month;
            year_d  = bus.set_year;
            state_d = VERIFY;
            busy_d  = 1'b1;
          end else begin
            set_err_d = 1'b1;
          end
        end else if (bus.day_tick) begin
          day_d       = inc_day;
          month_d     = inc_month;
          year_d      = inc_year;
          year_wrap_d = inc_wrap;
        end
      end
      VERIFY: begin
        // max_day now reflects the loaded month/year; a zero max_day is never written into day.
        if ((day_q > bus.max_day) && (bus.max_day != 5'd0)) begin
          day_d     = bus.max_day;
          set_err_d = 1'b1;
        end
        if (bus.day_tick) begin
          pend_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      day_q       <= 5'd1;
      month_q     <= 4'd1;
      year_q      <= 10'd0;
      busy_q      <= 1'b0;
      set_err_q   <= 1'b0;
      year_wrap_q <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      day_q       <= day_d;
      month_q     <= month_d;
      year_q      <= year_d;
      busy_q      <= busy_d;
      set_err_q   <= set_err_d;
      year_wrap_q <= year_wrap_d;
      pend_q      <= pend_d;
    end
  end

  assign bus.day       = day_q;
  assign bus.month     = month_q;
  assign bus.year      = year_q;
  assign bus.busy      = busy_q;
  assign bus.set_err   = set_err_q;
  assign bus.year_wrap = year_wrap_q;

endmodule

// File: tb/tb_date_counter.sv
// Bench for date_counter: directed calendar cases plus randomized ticks/loads against a
// day-serial calendar model (days since 2025-01-01).
module tb_date_counter;
  localparam int YEAR_MAX = 974;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   ys[0:YEAR_MAX+1];
  int   total_days;

  date_counter_if dif();

  date_counter #(.YEAR_MAX(YEAR_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  always #5 clk = ~clk;

  function automatic bit is_leap(int yo);
    int y;
    y = 2025 + yo;
    return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
  endfunction

  function automatic int dim(int m, int yo);
    case (m)
      2:           return is_leap(yo) ? 29 : 28;
      4, 6, 9, 11: return 30;
      default:     return 31;
    endcase
  endfunction

  // Stand-in for leap_year_check.
  assign dif.max_day = 5'(dim(int'(dif.month), int'(dif.year)));

  function automatic int to_serial(int d, int m, int y);
    int n;
    n = ys[y];
    for (int k = 1; k < m; k++) n += dim(k, y);
    return n + d - 1;
  endfunction

  function automatic logic [18:0] from_serial(int n);
    int lo, hi, mid, r, m;
    lo = 0;
    hi = YEAR_MAX;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (ys[mid] <= n) lo = mid;
      else hi = mid - 1;
    end
    r = n - ys[lo];
    m = 1;
    while (r >= dim(m, lo)) begin
      r -= dim(m, lo);
      m++;
    end
    return {5'(r + 1), 4'(m), 10'(lo)};
  endfunction

  function automatic logic [18:0] pk(int d, int m, int y);
    return {5'(d), 4'(m), 10'(y)};
  endfunction

  task automatic cyc(input bit tk, input bit se, input int sd, input int sm, input int sy);
    dif.day_tick  = tk;
    dif.set_en    = se;
    dif.set_day   = 5'(sd);
    dif.set_month = 4'(sm);
    dif.set_year  = 10'(sy);
    @(posedge clk);
    #1;
    dif.day_tick = 1'b0;
    dif.set_en   = 1'b0;
  endtask

  task automatic test_reset();
    logic [21:0] got, exp;
    got = {dif.day, dif.month, dif.year, dif.busy, dif.set_err, dif.year_wrap};
    exp = {pk(1, 1, 0), 3'b000};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL reset_state: got %h want %h", got, exp);
    end
    cyc(0, 0, 0, 0, 0);
    checks++;
    if ({dif.day, dif.month, dif.year} !== pk(1, 1, 0)) begin
      failures++;
      $display("FAIL reset_idle: got %0d/%0d/%0d want 1/1/0", dif.day, dif.month, dif.year);
    end
    cyc(0, 1, 15, 7, 100);
    checks++;
    if ({dif.day, dif.month, dif.year, dif.busy} !== {pk(15, 7, 100), 1'b1}) begin
      failures++;
      $display("FAIL reset_preload: got %0d/%0d/%0d busy=%b want 15/7/100 busy=1",
               dif.day, dif.month, dif.year, dif.busy);
    end
    #2 rst = 1'b1;
    #1;
    got = {dif.day, dif.month, dif.year, dif.busy, dif.set_err, dif.year_wrap};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL reset_async: got %h want %h", got, exp);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(0, 0, 0, 0, 0);
    got = {dif.day, dif.month, dif.year, dif.busy, dif.set_err, dif.year_wrap};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL reset_release: got %h want %h", got, exp);
    end
  endtask

  task automatic test_rollover();
    int tbl[4][6] = '{'{28, 2, 3, 29, 2, 3}, '{28, 2, 75, 1, 3, 75},
                      '{29, 2, 375, 1, 3, 375}, '{30, 4, 0, 1, 5, 0}};
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, tbl[i][0], tbl[i][1], tbl[i][2]);
      cyc(0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      checks++;
      if ({dif.day, dif.month, dif.year} !== pk(tbl[i][3], tbl[i][4], tbl[i][5])) begin
        failures++;
        $display("FAIL rollover_%0d: got %0d/%0d/%0d want %0d/%0d/%0d", i,
                 dif.day, dif.month, dif.year, tbl[i][3], tbl[i][4], tbl[i][5]);
      end
    end
  endtask

  task automatic test_year_wrap();
    cyc(0, 1, 31, 12, YEAR_MAX);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    checks++;
    if ({dif.day, dif.month, dif.year, dif.year_wrap} !== {pk(1, 1, 0), 1'b1}) begin
      failures++;
      $display("FAIL wrap_tick: got %0d/%0d/%0d wrap=%b want 1/1/0 wrap=1",
               dif.day, dif.month, dif.year, dif.year_wrap);
    end
    cyc(0, 0, 0, 0, 0);
    checks++;
    if (dif.year_wrap !== 1'b0) begin
      failures++;
      $display("FAIL wrap_one_cycle: got wrap=%b want 0", dif.year_wrap);
    end
    cyc(0, 1, 31, 12, 10);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    checks++;
    if ({dif.day, dif.month, dif.year, dif.year_wrap} !== {pk(1, 1, 11), 1'b0}) begin
      failures++;
      $display("FAIL year_inc: got %0d/%0d/%0d wrap=%b want 1/1/11 wrap=0",
               dif.day, dif.month, dif.year, dif.year_wrap);
    end
  endtask

  task automatic test_set_validation();
    int bad[3][3] = '{'{10, 13, 5}, '{10, 5, 975}, '{0, 5, 0}};
    cyc(0, 1, 31, 2, 0);
    checks++;
    if ({dif.day, dif.month, dif.year, dif.busy, dif.set_err} !== {pk(31, 2, 0), 2'b10}) begin
      failures++;
      $display("FAIL clamp_load: got %0d/%0d/%0d busy=%b err=%b want 31/2/0 busy=1 err=0",
               dif.day, dif.month, dif.year, dif.busy, dif.set_err);
    end
    cyc(0, 0, 0, 0, 0);
    checks++;
    if ({dif.day, dif.month, dif.year, dif.busy, dif.set_err} !== {pk(28, 2, 0), 2'b01}) begin
      failures++;
      $display("FAIL clamp_verify: got %0d/%0d/%0d busy=%b err=%b want 28/2/0 busy=0 err=1",
               dif.day, dif.month, dif.year, dif.busy, dif.set_err);
    end
    cyc(0, 0, 0, 0, 0);
    checks++;
    if (dif.set_err !== 1'b0) begin
      failures++;
      $display("FAIL clamp_err_pulse: got err=%b want 0", dif.set_err);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, bad[i][0], bad[i][1], bad[i][2]);
      checks++;
      if ({dif.day, dif.month, dif.year, dif.busy, dif.set_err} !== {pk(28, 2, 0), 2'b01}) begin
        failures++;
        $display("FAIL reject_%0d: got %0d/%0d/%0d busy=%b err=%b want 28/2/0 busy=0 err=1", i,
                 dif.day, dif.month, dif.year, dif.busy, dif.set_err);
      end
      cyc(0, 0, 0, 0, 0);
      checks++;
      if ({dif.day, dif.month, dif.year, dif.set_err} !== {pk(28, 2, 0), 1'b0}) begin
        failures++;
        $display("FAIL reject_after_%0d: got %0d/%0d/%0d err=%b want 28/2/0 err=0", i,
                 dif.day, dif.month, dif.year, dif.set_err);
      end
    end
  endtask

  task automatic test_back_to_back();
    cyc(1, 1, 10, 6, 20);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    checks++;
    if ({dif.day, dif.month, dif.year, dif.set_err} !== {pk(10, 6, 20), 1'b0}) begin
      failures++;
      $display("FAIL set_beats_tick: got %0d/%0d/%0d err=%b want 10/6/20 err=0",
               dif.day, dif.month, dif.year, dif.set_err);
    end
    cyc(0, 1, 31, 2, 0);
    cyc(1, 0, 0, 0, 0);
    checks++;
    if ({dif.day, dif.month, dif.year, dif.set_err} !== {pk(28, 2, 0), 1'b1}) begin
      failures++;
      $display("FAIL verify_tick_clamp: got %0d/%0d/%0d err=%b want 28/2/0 err=1",
               dif.day, dif.month, dif.year, dif.set_err);
    end
    cyc(0, 0, 0, 0, 0);
    checks++;
    if ({dif.day, dif.month, dif.year} !== pk(1, 3, 0)) begin
      failures++;
      $display("FAIL pend_apply: got %0d/%0d/%0d want 1/3/0", dif.day, dif.month, dif.year);
    end
    cyc(0, 0, 0, 0, 0);
    checks++;
    if ({dif.day, dif.month, dif.year} !== pk(1, 3, 0)) begin
      failures++;
      $display("FAIL pend_clear: got %0d/%0d/%0d want 1/3/0", dif.day, dif.month, dif.year);
    end
    // Tick and a load both arrive in the pend cycle: load ignored, tick banked.
    cyc(0, 1, 31, 2, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 5, 5, 5);
    checks++;
    if ({dif.day, dif.month, dif.year, dif.busy} !== {pk(1, 3, 0), 1'b0}) begin
      failures++;
      $display("FAIL pend_set_ignored: got %0d/%0d/%0d busy=%b want 1/3/0 busy=0",
               dif.day, dif.month, dif.year, dif.busy);
    end
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    checks++;
    if ({dif.day, dif.month, dif.year} !== pk(2, 3, 0)) begin
      failures++;
      $display("FAIL pend_double: got %0d/%0d/%0d want 2/3/0", dif.day, dif.month, dif.year);
    end
  endtask

  task automatic test_random();
    int rn, sd, sm, sy, cd, gap;
    bit valid;
    logic [18:0] exp;
    cyc(0, 1, 2, 2, 500);
    cyc(0, 0, 0, 0, 0);
    rn = to_serial(2, 2, 500);
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 9) < 6) begin
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        exp = from_serial((rn + 1) % total_days);
        checks++;
        if ({dif.day, dif.month, dif.year, dif.year_wrap} !== {exp, rn == total_days - 1}) begin
          failures++;
          $display("FAIL rand_tick_%0d: got %0d/%0d/%0d wrap=%b want %0d/%0d/%0d", it,
                   dif.day, dif.month, dif.year, dif.year_wrap, exp[18:14], exp[13:10], exp[9:0]);
        end
        rn = (rn + 1) % total_days;
      end else begin
        sd = $urandom_range(0, 31);
        sm = $urandom_range(0, 15);
        sy = ($urandom_range(0, 7) == 0) ? $urandom_range(900, 1023) : $urandom_range(0, YEAR_MAX);
        valid = (sm >= 1) && (sm <= 12) && (sd >= 1) && (sy <= YEAR_MAX);
        cyc(1'($urandom_range(0, 1)), 1, sd, sm, sy);
        if (valid) begin
          checks++;
          if ({dif.day, dif.month, dif.year, dif.busy} !== {pk(sd, sm, sy), 1'b1}) begin
            failures++;
            $display("FAIL rand_load_%0d: got %0d/%0d/%0d busy=%b want %0d/%0d/%0d busy=1", it,
                     dif.day, dif.month, dif.year, dif.busy, sd, sm, sy);
          end
          cyc(0, 0, 0, 0, 0);
          cd = (sd > dim(sm, sy)) ? dim(sm, sy) : sd;
          checks++;
          if ({dif.day, dif.month, dif.year, dif.set_err} !== {pk(cd, sm, sy), sd > cd}) begin
            failures++;
            $display("FAIL rand_verify_%0d: got %0d/%0d/%0d err=%b want %0d/%0d/%0d", it,
                     dif.day, dif.month, dif.year, dif.set_err, cd, sm, sy);
          end
          rn = to_serial(cd, sm, sy);
        end else begin
          exp = from_serial(rn);
          checks++;
          if ({dif.day, dif.month, dif.year, dif.busy, dif.set_err} !== {exp, 2'b01}) begin
            failures++;
            $display("FAIL rand_reject_%0d: got %0d/%0d/%0d busy=%b err=%b want %0d/%0d/%0d err=1",
                     it, dif.day, dif.month, dif.year, dif.busy, dif.set_err,
                     exp[18:14], exp[13:10], exp[9:0]);
          end
        end
      end
    end
  endtask

  task automatic test_long_run();
    int rn, wraps, starts[2], lens[2];
    logic [18:0] exp;
    starts = '{0, 965};
    lens   = '{4000, 4000};
    wraps  = 0;
    for (int s = 0; s < 2; s++) begin
      cyc(0, 1, 1, 1, starts[s]);
      cyc(0, 0, 0, 0, 0);
      rn = to_serial(1, 1, starts[s]);
      for (int i = 0; i < lens[s]; i++) begin
        cyc(1, 0, 0, 0, 0);
        exp = from_serial((rn + 1) % total_days);
        checks++;
        if ({dif.day, dif.month, dif.year, dif.year_wrap} !== {exp, rn == total_days - 1}) begin
          failures++;
          $display("FAIL long_run_%0d_%0d: got %0d/%0d/%0d wrap=%b want %0d/%0d/%0d", s, i,
                   dif.day, dif.month, dif.year, dif.year_wrap, exp[18:14], exp[13:10], exp[9:0]);
        end
        if (dif.year_wrap === 1'b1) wraps++;
        rn = (rn + 1) % total_days;
      end
    end
    checks++;
    if (wraps != 1) begin
      failures++;
      $display("FAIL long_run_wraps: got %0d want 1", wraps);
    end
  endtask

  initial begin
    dif.day_tick  = 1'b0;
    dif.set_en    = 1'b0;
    dif.set_day   = 5'd0;
    dif.set_month = 4'd0;
    dif.set_year  = 10'd0;
    ys[0] = 0;
    for (int i = 1; i <= YEAR_MAX + 1; i++) ys[i] = ys[i-1] + (is_leap(i - 1) ? 366 : 365);
    total_days = ys[YEAR_MAX+1];
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_rollover();
    test_year_wrap();
    test_set_validation();
    test_back_to_back();
    test_random();
    test_long_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
